// File: rtl/aes_key_pkg.sv
// Shared constants, state encoding and word helpers for the AES-128 key-schedule engine.
package aes_key_pkg;

    localparam int NK     = 4;
    localparam int NR_MAX = 10;
    localparam int KEY_W  = 128;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_subword.sv
// SubWord: independent AES S-box substitution of each byte of a 32-bit word.
// Purely combinational; table held as a packed constant, entry 0 in the top byte.
module aes_key_expand_seq_subword (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_expand_seq.sv
// AES-128 key schedule: one round key per cycle (idx 0..NUM_ROUNDS) under valid/ready.
// Optional AES_KEY_STORE_EN adds an 11-entry round-key store with a combinational read port.
module aes_key_expand_seq
    import aes_key_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [KEY_W-1:0] KEY_I,
    input  logic             START_I,
    input  logic             RK_READY_I,
    output logic [KEY_W-1:0] RK_O,
    output logic [3:0]       RK_IDX_O,
    output logic             RK_VALID_O,
    output logic             BUSY_O,
    output logic             DONE_O
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]       RD_IDX_I,
    output logic [KEY_W-1:0] RD_KEY_O
`endif
);

    localparam int          LAST     = (NUM_ROUNDS > NR_MAX) ? NR_MAX : NUM_ROUNDS;
    localparam logic [3:0]  LAST_IDX = 4'(LAST);
    localparam int          WORD_W   = KEY_W / NK;

    state_t             r_state, w_state_nxt;
    logic [KEY_W-1:0]   r_rk;
    logic [3:0]         r_idx;
    logic               r_done;
    logic               w_load, w_adv, w_done_nxt, w_transfer;

    logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t;
    logic [WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;
    logic [3:0]         w_next_idx;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
    assign w_next_idx = r_idx + 4'd1;
    assign w_rot      = rot_word(w_w3);

    aes_key_expand_seq_subword u_subword (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_t  = w_sub ^ {rcon(w_next_idx), 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign w_transfer = (r_state == EMIT) && RK_READY_I;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (START_I) begin
                    w_load      = 1'b1;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_transfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_rk    <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_rk  <= KEY_I;
                r_idx <= '0;
            end else if (w_adv) begin
                r_rk  <= {w_n0, w_n1, w_n2, w_n3};
                r_idx <= w_next_idx;
            end
        end
    end

    assign RK_O       = r_rk;
    assign RK_IDX_O   = r_idx;
    assign RK_VALID_O = (r_state == EMIT);
    assign BUSY_O     = (r_state == EMIT);
    assign DONE_O     = r_done;

`ifdef AES_KEY_STORE_EN
    logic [KEY_W-1:0] r_store [0:NR_MAX];

    // Each key is captured at its own transfer, so a new expansion overwrites entries in order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i <= NR_MAX; i++) r_store[i] <= '0;
        end else if (w_transfer) begin
            r_store[r_idx] <= r_rk;
        end
    end

    always_comb begin
        RD_KEY_O = '0;
        if (RD_IDX_I <= 4'(NR_MAX)) RD_KEY_O = r_store[RD_IDX_I];
    end
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Randomised bench for aes_key_expand_seq: a full-round instance and a NUM_ROUNDS=2 instance,
// both compared every cycle against a GF(2^8)-arithmetic key-schedule model.
module tb_aes_key_expand_seq;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         start [2];
    logic [127:0] key   [2];
    logic         rdy   [2];
    logic [127:0] rk    [2];
    logic [3:0]   idx   [2];
    logic         vld   [2];
    logic         busy  [2];
    logic         done  [2];
    int           nr    [2] = '{10, 2};

    int checks = 0;
    int fails  = 0;

`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx [2];
    logic [127:0] rd_key [2];
`endif

    always #5 CLK = ~CLK;

    aes_key_expand_seq #(.NUM_ROUNDS(10)) dut0 (
        .CLK(CLK), .RST(RST), .KEY_I(key[0]), .START_I(start[0]), .RK_READY_I(rdy[0]),
        .RK_O(rk[0]), .RK_IDX_O(idx[0]), .RK_VALID_O(vld[0]), .BUSY_O(busy[0]), .DONE_O(done[0])
`ifdef AES_KEY_STORE_EN
        , .RD_IDX_I(rd_idx[0]), .RD_KEY_O(rd_key[0])
`endif
    );

    aes_key_expand_seq #(.NUM_ROUNDS(2)) dut1 (
        .CLK(CLK), .RST(RST), .KEY_I(key[1]), .START_I(start[1]), .RK_READY_I(rdy[1]),
        .RK_O(rk[1]), .RK_IDX_O(idx[1]), .RK_VALID_O(vld[1]), .BUSY_O(busy[1]), .DONE_O(done[1])
`ifdef AES_KEY_STORE_EN
        , .RD_IDX_I(rd_idx[1]), .RD_KEY_O(rd_key[1])
`endif
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [7:0] rc_ref(input int i);
        logic [7:0] r = 8'h01;
        for (int k = 1; k < i; k++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input int i);
        logic [31:0] w [8];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[j] = k[127 - 32*j -: 32];
        t = {sbox_ref(w[3][23:16]), sbox_ref(w[3][15:8]), sbox_ref(w[3][7:0]), sbox_ref(w[3][31:24])};
        w[4] = w[0] ^ t ^ {rc_ref(i), 24'h0};
        for (int j = 5; j < 8; j++) w[j] = w[j-4] ^ w[j-1];
        return {w[4], w[5], w[6], w[7]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_active [2];
    logic [3:0]   m_idx    [2];
    logic [127:0] m_rk     [2];
    logic         m_done   [2];
    logic [127:0] m_key0   [2];

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_active[i] <= 1'b0; m_idx[i] <= '0; m_rk[i] <= '0; m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_active[i]) begin
                    if (start[i]) begin
                        m_active[i] <= 1'b1; m_idx[i] <= '0; m_rk[i] <= key[i]; m_key0[i] <= key[i];
                    end
                end else if (rdy[i]) begin
                    if (int'(m_idx[i]) == nr[i]) begin
                        m_active[i] <= 1'b0; m_done[i] <= 1'b1;
                    end else begin
                        m_rk[i]  <= next_key(m_rk[i], int'(m_idx[i]) + 1);
                        m_idx[i] <= m_idx[i] + 4'd1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid%0d", i), vld[i],  m_active[i]);
            chk($sformatf("busy%0d", i),  busy[i], m_active[i]);
            chk($sformatf("done%0d", i),  done[i], m_done[i]);
            chk($sformatf("idx%0d", i),   idx[i],  m_idx[i]);
            chk($sformatf("rk%0d", i),    rk[i],   m_rk[i]);
        end
        if (vld[0] && m_key0[0] == FIPS_KEY && idx[0] == 4'd1)  chk("fips_idx1_lit", rk[0], FIPS_K1);
        if (vld[0] && m_key0[0] == FIPS_KEY && idx[0] == 4'd10) chk("fips_idx10_lit", rk[0], FIPS_K10);
        if (vld[0] && m_key0[0] == SEQ_KEY  && idx[0] == 4'd10) chk("seq_idx10_lit", rk[0], SEQ_K10);
    end

    // ---------------- stimulus ----------------
    task automatic run0(input logic [127:0] k, input bit rand_rdy, input bit inject, output int cyc);
        bit seen = 0;
        @(posedge CLK); #1 start[0] = 1'b1; key[0] = k;
        @(posedge CLK); #1 start[0] = 1'b0; key[0] = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            rdy[0] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start[0] = (inject && c == 3);
            @(posedge CLK); #1;
            cyc++;
            if (done[0]) seen = 1;
        end
        start[0] = 1'b0;
        chk("done0_seen", seen, 1'b1);
    endtask

    int cyc;
    bit seen1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; key[i] = '0; rdy[i] = 0;
`ifdef AES_KEY_STORE_EN
            rd_idx[i] = '0;
`endif
        end
        #1 RST = 1'b1;
        #2;
        chk("rst_rk", rk[0], 128'h0);
        chk("rst_valid", vld[0], 1'b0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        run0(FIPS_KEY, 0, 0, cyc);
        chk("fips_cycles", cyc, 11);
        run0(FIPS_KEY, 1, 0, cyc);
        run0(FIPS_KEY, 1, 1, cyc);

        // asynchronous reset in the middle of an expansion
        @(posedge CLK); #1 start[0] = 1'b1; key[0] = FIPS_KEY; rdy[0] = 1'b1;
        @(posedge CLK); #1 start[0] = 1'b0;
        for (int c = 0; c < 50 && !(vld[0] && idx[0] == 4'd5); c++) begin
            @(posedge CLK); #1;
        end
        chk("reached_idx5", idx[0], 4'd5);
        #2 RST = 1'b1;
        #1;
        chk("arst_rk", rk[0], 128'h0);
        chk("arst_idx", idx[0], 4'd0);
        chk("arst_valid", vld[0], 1'b0);
        chk("arst_busy", busy[0], 1'b0);
        chk("arst_done", done[0], 1'b0);
        @(posedge CLK); #1 RST = 1'b0;
        run0(SEQ_KEY, 0, 0, cyc);

        // short instance: restart inside the DONE pulse cycle
        @(posedge CLK); #1 start[1] = 1'b1; key[1] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK); #1 start[1] = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            seen1 = 0;
            for (int c = 0; c < 100 && !seen1; c++) begin
                rdy[1] = 1'($urandom_range(0, 1));
                @(posedge CLK); #1;
                if (done[1]) seen1 = 1;
            end
            chk($sformatf("done1_seen_%0d", pass), seen1, 1'b1);
            if (pass == 0) begin
                start[1] = 1'b1; key[1] = {$urandom, $urandom, $urandom, $urandom};
                @(posedge CLK); #1 start[1] = 1'b0;
                chk("restart_in_done", vld[1], 1'b1);
            end
        end

        for (int r = 0; r < 4; r++) run0({$urandom, $urandom, $urandom, $urandom}, 1, r[0], cyc);

`ifdef AES_KEY_STORE_EN
        begin
            logic [127:0] exp_k = m_key0[0];
            for (int r = 0; r < 16; r++) begin
                rd_idx[0] = 4'(r);
                #1;
                chk($sformatf("store_%0d", r), rd_key[0], (r <= 10) ? exp_k : 128'h0);
                if (r < 10) exp_k = next_key(exp_k, r + 1);
            end
            rd_idx[1] = 4'd0;
            #1 chk("store1_0", rd_key[1], m_key0[1]);
        end
`endif

        repeat (2) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
